// File: rtl/fru_pkg.sv
// Shared types and default widths for the FRU trigger generator.
// Lane state encoding and mode bit layout are visible to firmware through TrigState/RegMode.
package fru_pkg;

    localparam int DEF_NUM_TRIGGERS = 2;
    localparam int DEF_SIGNAL_WIDTH = 8;
    localparam int DEF_CNT_WIDTH    = 8;
    localparam int DEF_WIN_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        FIRED    = 2'd2
    } trig_state_e;

    // Field order matches RegMode: bit1 = sticky, bit0 = edge event.
    typedef struct packed {
        logic sticky;
        logic is_edge;
    } trig_mode_t;

endpackage

// File: rtl/fru_trigger_unit.sv
// One trigger lane: masked compare, event counter, window timer and FSM.
// qin is registered and always equals (state == FIRED).
module fru_trigger_unit
    import fru_pkg::*;
#(
    parameter int SIGNAL_WIDTH = DEF_SIGNAL_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int WIN_WIDTH    = DEF_WIN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIGNAL_WIDTH-1:0] signal,
    input  logic [SIGNAL_WIDTH-1:0] match_val,
    input  logic [SIGNAL_WIDTH-1:0] match_mask,
    input  logic [CNT_WIDTH-1:0]    threshold,
    input  logic [WIN_WIDTH-1:0]    window,
    input  logic [1:0]              mode,
    input  logic                    enable,
    input  logic                    clear,
    output logic                    qin,
    output logic [1:0]              state_dbg
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

    trig_state_e            state;
    logic [CNT_WIDTH-1:0]   count;
    logic [WIN_WIDTH-1:0]   timer;
    logic                   match_q;

    trig_mode_t             mode_s;
    logic                   match;
    logic                   evt;
    logic [CNT_WIDTH-1:0]   thr_eff;
    logic                   fire_hit;
    logic                   timeout;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        mode_s   = trig_mode_t'(mode);
        match    = ((signal ^ match_val) & match_mask) == '0;
        evt      = mode_s.is_edge ? (match & ~match_q) : match;
        thr_eff  = (threshold == '0) ? CNT_ONE : threshold;
        fire_hit = evt && ((count + CNT_ONE) == thr_eff);
        timeout  = (window != '0) && (timer == (window - WIN_ONE));
    end

    // NOTE: state registers use non-blocking assignments so all lanes update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            timer   <= '0;
            match_q <= 1'b0;
            qin     <= 1'b0;
        end else begin
            match_q <= match;
            if (clear || !enable) begin
                state <= IDLE;
                count <= '0;
                timer <= '0;
                qin   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fire_hit) begin
                            state <= FIRED;
                            qin   <= 1'b1;
                        end else if (evt) begin
                            state <= COUNTING;
                            count <= CNT_ONE;
                            timer <= '0;
                        end
                    end
                    COUNTING: begin
                        // A firing event beats a timeout in the same cycle.
                        if (fire_hit) begin
                            state <= FIRED;
                            count <= '0;
                            timer <= '0;
                            qin   <= 1'b1;
                        end else if (timeout) begin
                            state <= IDLE;
                            count <= '0;
                            timer <= '0;
                        end else begin
                            if (evt) count <= count + CNT_ONE;
                            if (timer != '1) timer <= timer + WIN_ONE;
                        end
                    end
                    FIRED: begin
                        // Pulse mode spends this cycle re-arming; events here are dropped.
                        if (!mode_s.sticky) begin
                            state <= IDLE;
                            count <= '0;
                            timer <= '0;
                            qin   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                        timer <= '0;
                        qin   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: rtl/fru_trigger_gen.sv
// Builds the Qin trigger vector for the FRU PLA from NUM_TRIGGERS independent lanes.
// All outputs come straight from lane registers.
module fru_trigger_gen
    import fru_pkg::*;
#(
    parameter int NUM_TRIGGERS = DEF_NUM_TRIGGERS,
    parameter int SIGNAL_WIDTH = DEF_SIGNAL_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int WIN_WIDTH    = DEF_WIN_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_TRIGGERS-1:0][SIGNAL_WIDTH-1:0] SignalIn,
    input  logic [NUM_TRIGGERS-1:0][SIGNAL_WIDTH-1:0] RegMatchVal,
    input  logic [NUM_TRIGGERS-1:0][SIGNAL_WIDTH-1:0] RegMatchMask,
    input  logic [NUM_TRIGGERS-1:0][CNT_WIDTH-1:0]    RegThreshold,
    input  logic [NUM_TRIGGERS-1:0][WIN_WIDTH-1:0]    RegWindow,
    input  logic [NUM_TRIGGERS-1:0][1:0]              RegMode,
    input  logic [NUM_TRIGGERS-1:0]                   RegEnable,
    input  logic [NUM_TRIGGERS-1:0]                   TrigClear,
    output logic [NUM_TRIGGERS-1:0]                   Qin,
    output logic [NUM_TRIGGERS-1:0][1:0]              TrigState
);

    for (genvar g = 0; g < NUM_TRIGGERS; g++) begin : g_lane
        fru_trigger_unit #(
            .SIGNAL_WIDTH (SIGNAL_WIDTH),
            .CNT_WIDTH    (CNT_WIDTH),
            .WIN_WIDTH    (WIN_WIDTH)
        ) u_unit (
            .clk        (clk),
            .rst        (rst),
            .signal     (SignalIn[g]),
            .match_val  (RegMatchVal[g]),
            .match_mask (RegMatchMask[g]),
            .threshold  (RegThreshold[g]),
            .window     (RegWindow[g]),
            .mode       (RegMode[g]),
            .enable     (RegEnable[g]),
            .clear      (TrigClear[g]),
            .qin        (Qin[g]),
            .state_dbg  (TrigState[g])
        );
    end

endmodule

// File: tb/tb_fru_trigger_gen.sv
// Directed bench for fru_trigger_gen: per-scenario tasks with hand-computed state/Qin sequences.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
module tb_fru_trigger_gen;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0][7:0]  SignalIn;
    logic [N-1:0][7:0]  RegMatchVal;
    logic [N-1:0][7:0]  RegMatchMask;
    logic [N-1:0][7:0]  RegThreshold;
    logic [N-1:0][15:0] RegWindow;
    logic [N-1:0][1:0]  RegMode;
    logic [N-1:0]       RegEnable;
    logic [N-1:0]       TrigClear;
    logic [N-1:0]       Qin;
    logic [N-1:0][1:0]  TrigState;

    int passed = 0;
    int total  = 0;

    fru_trigger_gen #(
        .NUM_TRIGGERS (N),
        .SIGNAL_WIDTH (8),
        .CNT_WIDTH    (8),
        .WIN_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .SignalIn     (SignalIn),
        .RegMatchVal  (RegMatchVal),
        .RegMatchMask (RegMatchMask),
        .RegThreshold (RegThreshold),
        .RegWindow    (RegWindow),
        .RegMode      (RegMode),
        .RegEnable    (RegEnable),
        .TrigClear    (TrigClear),
        .Qin          (Qin),
        .TrigState    (TrigState)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int i, input logic [7:0] val, input logic [7:0] mask,
                       input logic [7:0] thr, input logic [15:0] win, input logic [1:0] mode);
        RegMatchVal[i]  = val;
        RegMatchMask[i] = mask;
        RegThreshold[i] = thr;
        RegWindow[i]    = win;
        RegMode[i]      = mode;
    endtask

    // Park a lane in IDLE with a known match_q history.
    task automatic park(input int i, input logic [7:0] sig);
        RegEnable[i] = 1'b0;
        SignalIn[i]  = sig;
        tick();
    endtask

    task automatic test_reset();
        cfg(0, 8'h00, 8'h00, 8'd1, 16'd0, 2'b00);
        cfg(1, 8'h00, 8'h00, 8'd1, 16'd0, 2'b00);
        RegEnable = 2'b11;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (Qin !== 2'b00 || TrigState !== 4'b0000) begin
            $display("FAIL reset_hold: Qin=%b TrigState=%b, required Qin=00 TrigState=0000", Qin, TrigState);
        end else passed++;
        rst = 1'b0;
        #2;
        total++;
        if (Qin !== 2'b00) begin
            $display("FAIL reset_release: Qin=%b, required 00", Qin);
        end else passed++;
        tick();
        total++;
        if (Qin !== 2'b11 || TrigState !== {2'd2, 2'd2}) begin
            $display("FAIL reset_first_fire: Qin=%b TrigState=%b, required Qin=11 TrigState=1010", Qin, TrigState);
        end else passed++;
        park(0, 8'h00);
        park(1, 8'h00);
    endtask

    task automatic test_level_threshold();
        logic [1:0] st[8] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        cfg(0, 8'hA5, 8'hFF, 8'd3, 16'd0, 2'b00);
        RegEnable[0] = 1'b1;
        SignalIn[0]  = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (Qin[0] !== (st[k] == 2'd2) || TrigState[0] !== st[k]) begin
                $display("FAIL level_thr step %0d: Qin=%b state=%0d, required Qin=%b state=%0d",
                         k, Qin[0], TrigState[0], (st[k] == 2'd2), st[k]);
            end else passed++;
        end
        total++;
        if (Qin[1] !== 1'b0) begin
            $display("FAIL level_thr_lane1_idle: Qin[1]=%b, required 0", Qin[1]);
        end else passed++;
        park(0, 8'h00);
    endtask

    task automatic test_edge_sticky();
        logic [7:0] sig[10] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5};
        logic [1:0] st[10]  = '{2'd1,  2'd1,  2'd2,  2'd2,  2'd2,  2'd2,  2'd0,  2'd0,  2'd0,  2'd1};
        logic       clr[10] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
        cfg(0, 8'hA5, 8'hFF, 8'd2, 16'd0, 2'b11);
        park(0, 8'h00);
        RegEnable[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            SignalIn[0]  = sig[k];
            TrigClear[0] = clr[k];
            tick();
            total++;
            if (Qin[0] !== (st[k] == 2'd2) || TrigState[0] !== st[k]) begin
                $display("FAIL edge_sticky step %0d: Qin=%b state=%0d, required Qin=%b state=%0d",
                         k, Qin[0], TrigState[0], (st[k] == 2'd2), st[k]);
            end else passed++;
        end
        TrigClear[0] = 1'b0;
        park(0, 8'h00);
    endtask

    task automatic test_window();
        // Row 0: timeout; row 1: third event fires; row 2: firing event on the timeout cycle;
        // row 3: non-firing event on the timeout cycle still times out.
        logic [7:0] sig[4][6] = '{
            '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00},
            '{8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h00},
            '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00},
            '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00}};
        logic [1:0] st[4][6] = '{
            '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0},
            '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0},
            '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0},
            '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0}};
        cfg(0, 8'hA5, 8'hFF, 8'd3, 16'd4, 2'b00);
        for (int v = 0; v < 4; v++) begin
            park(0, 8'h00);
            RegEnable[0] = 1'b1;
            for (int k = 0; k < 6; k++) begin
                SignalIn[0] = sig[v][k];
                tick();
                total++;
                if (Qin[0] !== (st[v][k] == 2'd2) || TrigState[0] !== st[v][k]) begin
                    $display("FAIL window v%0d step %0d: Qin=%b state=%0d, required Qin=%b state=%0d",
                             v, k, Qin[0], TrigState[0], (st[v][k] == 2'd2), st[v][k]);
                end else passed++;
            end
        end
        park(0, 8'h00);
    endtask

    task automatic test_conflicts();
        cfg(0, 8'hA5, 8'hFF, 8'd1, 16'd0, 2'b00);
        RegEnable[0] = 1'b1;
        SignalIn[0]  = 8'hA5;
        TrigClear[0] = 1'b1;
        tick();
        total++;
        if (Qin[0] !== 1'b0 || TrigState[0] !== 2'd0) begin
            $display("FAIL clear_beats_fire: Qin=%b state=%0d, required Qin=0 state=0", Qin[0], TrigState[0]);
        end else passed++;
        TrigClear[0] = 1'b0;
        tick();
        total++;
        if (Qin[0] !== 1'b1 || TrigState[0] !== 2'd2) begin
            $display("FAIL fire_after_clear: Qin=%b state=%0d, required Qin=1 state=2", Qin[0], TrigState[0]);
        end else passed++;

        cfg(0, 8'hA5, 8'hFF, 8'd1, 16'd0, 2'b10);
        park(0, 8'hA5);
        RegEnable[0] = 1'b1;
        tick();
        tick();
        total++;
        if (Qin[0] !== 1'b1 || TrigState[0] !== 2'd2) begin
            $display("FAIL sticky_hold: Qin=%b state=%0d, required Qin=1 state=2", Qin[0], TrigState[0]);
        end else passed++;
        RegEnable[0] = 1'b0;
        tick();
        total++;
        if (Qin[0] !== 1'b0 || TrigState[0] !== 2'd0) begin
            $display("FAIL disable_sticky: Qin=%b state=%0d, required Qin=0 state=0", Qin[0], TrigState[0]);
        end else passed++;
        tick();
        total++;
        if (Qin[0] !== 1'b0 || TrigState[0] !== 2'd0) begin
            $display("FAIL disable_held: Qin=%b state=%0d, required Qin=0 state=0", Qin[0], TrigState[0]);
        end else passed++;
        park(0, 8'h00);
    endtask

    task automatic test_special();
        // Lane 0: mask 00, thr 2 -> period 3. Lane 1: mask 00, thr 0 -> alternates fire/re-arm.
        logic [7:0] sig[6] = '{8'h3C, 8'h00, 8'hFF, 8'h12, 8'h99, 8'h7E};
        logic [1:0] st0[6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        logic [1:0] st1[6] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
        cfg(0, 8'hA5, 8'h00, 8'd2, 16'd0, 2'b00);
        cfg(1, 8'h5A, 8'h00, 8'd0, 16'd0, 2'b00);
        RegEnable = 2'b11;
        for (int k = 0; k < 6; k++) begin
            SignalIn[0] = sig[k];
            SignalIn[1] = ~sig[k];
            tick();
            total++;
            if (Qin[0] !== (st0[k] == 2'd2) || TrigState[0] !== st0[k]) begin
                $display("FAIL mask_zero step %0d: Qin=%b state=%0d, required Qin=%b state=%0d",
                         k, Qin[0], TrigState[0], (st0[k] == 2'd2), st0[k]);
            end else passed++;
            total++;
            if (Qin[1] !== (st1[k] == 2'd2) || TrigState[1] !== st1[k]) begin
                $display("FAIL thr_zero step %0d: Qin=%b state=%0d, required Qin=%b state=%0d",
                         k, Qin[1], TrigState[1], (st1[k] == 2'd2), st1[k]);
            end else passed++;
        end
        park(0, 8'h00);
        park(1, 8'h00);
    endtask

    initial begin
        rst          = 1'b1;
        SignalIn     = '0;
        RegMatchVal  = '0;
        RegMatchMask = '0;
        RegThreshold = '0;
        RegWindow    = '0;
        RegMode      = '0;
        RegEnable    = '0;
        TrigClear    = '0;
        test_reset();
        test_level_threshold();
        test_edge_sticky();
        test_window();
        test_conflicts();
        test_special();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
